// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out stage.
package piso_pkg;

    typedef enum logic [0:0] {IDLE, SHIFT} piso_state_e;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/piso_counter.sv
// Mod-depth_p element index counter with synchronous clear; wraps on terminal count only.
import piso_pkg::*;

module piso_counter #(
    parameter  int depth_p = 128,
    localparam int idx_w   = idx_width(depth_p)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [idx_w-1:0] count_o,
    output logic             last_o
);

    logic [idx_w-1:0] count_q, count_d;

    assign last_o  = (count_q == idx_w'(depth_p - 1));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = last_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso.sv
// Parallel-in serial-out stage: one packed word in, depth_p elements out, lowest index first.
// Optional macro PISO_BACK2BACK_EN lets a new word load on the last element's handshake.
import piso_pkg::*;

module piso #(
    parameter int width_p = 8,
    parameter int depth_p = 128
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       valid_i,
    input  logic [width_p*depth_p-1:0] data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       ready_i
);

    localparam int idx_w = idx_width(depth_p);

    piso_state_e                     state_q, state_d;
    logic [depth_p-1:0][width_p-1:0] buf_q, buf_d;
    logic [idx_w-1:0]                idx;
    logic                            last;
    logic                            load;
    logic                            shift_hs;

    piso_counter #(
        .depth_p (depth_p)
    ) u_counter (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clr_i    (load),
        .en_i     (shift_hs),
        .count_o  (idx),
        .last_o   (last)
    );

    // Outputs are forced low while reset is asserted so nothing leaks mid-reset.
    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        if (reset_ni) begin
            if (state_q == IDLE) begin
                ready_o = 1'b1;
            end
`ifdef PISO_BACK2BACK_EN
            else begin
                ready_o = ready_i && last;
            end
`endif
            valid_o = (state_q == SHIFT);
        end
    end

    assign load     = valid_i && ready_o;
    assign shift_hs = valid_o && ready_i;
    assign data_o   = reset_ni ? buf_q[idx] : '0;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        if (load) begin
            buf_d = data_i;
        end
        case (state_q)
            IDLE:    if (load) state_d = SHIFT;
            // A load coinciding with the last handshake keeps streaming the new word.
            SHIFT:   if (shift_hs && last && !load) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_piso.sv
// Directed bench for piso (width 8, depth 4) with a queue-based reference model.
module tb_piso;

    localparam int W = 8;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           reset_ni;
    logic           valid_i;
    logic [W*D-1:0] data_i;
    logic           ready_o;
    logic           valid_o;
    logic [W-1:0]   data_o;
    logic           ready_i;

    int n_chk  = 0;
    int n_pass = 0;

    piso #(.width_p(W), .depth_p(D)) dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .ready_i  (ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: the pending elements of the word currently being replayed.
    logic [W-1:0] mq[$];
    logic         model_en = 1'b0;

    function automatic logic model_ready();
        if (!reset_ni) return 1'b0;
        if (mq.size() == 0) return 1'b1;
`ifdef PISO_BACK2BACK_EN
        return ready_i && (mq.size() == 1);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        if (!reset_ni) begin
            mq.delete();
        end else begin
            logic rdy;
            rdy = model_ready();
            if (mq.size() > 0 && ready_i) void'(mq.pop_front());
            if (valid_i && rdy)
                for (int k = 0; k < D; k++) mq.push_back(data_i[k*W +: W]);
        end
    end

    always @(negedge clk) begin
        if (model_en) begin
            logic ev;
            ev = reset_ni && (mq.size() > 0);
            chk("model_valid", {31'd0, valid_o}, {31'd0, ev});
            chk("model_ready", {31'd0, ready_o}, {31'd0, model_ready()});
            if (!reset_ni) chk("model_data_rst", {24'd0, data_o}, 32'd0);
            else if (ev)   chk("model_data", {24'd0, data_o}, {24'd0, mq[0]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_elem(input string name, input logic [7:0] b);
        chk({name, "_valid"}, {31'd0, valid_o}, 32'd1);
        chk({name, "_data"}, {24'd0, data_o}, {24'd0, b});
    endtask

    task automatic expect_idle(input string name);
        chk({name, "_valid"}, {31'd0, valid_o}, 32'd0);
        chk({name, "_ready"}, {31'd0, ready_o}, 32'd1);
    endtask

    // Drive a load that the next edge accepts, then drop valid_i.
    task automatic load_word(input logic [31:0] w);
        valid_i = 1'b1;
        data_i  = w;
        step();
        valid_i = 1'b0;
    endtask

    logic [7:0] rec_d[9];
    logic       rec_v[9];
    logic [7:0] exp_d[9];
    logic       exp_v[9];

    initial begin
        reset_ni = 1'b0;
        valid_i  = 1'b1;
        data_i   = 32'h44332211;
        ready_i  = 1'b1;
        #1;
        model_en = 1'b1;

        // 1. reset with valid_i asserted
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_valid", {31'd0, valid_o}, 32'd0);
            chk("rst_data", {24'd0, data_o}, 32'd0);
            chk("rst_ready", {31'd0, ready_o}, 32'd0);
        end
        reset_ni = 1'b1;
        valid_i  = 1'b0;
        #1;
        chk("rst_release_ready", {31'd0, ready_o}, 32'd1);
        step();

        // 2. basic stream
        load_word(32'h44332211);
        expect_elem("basic0", 8'h11);
        chk("basic_busy_ready", {31'd0, ready_o}, 32'd0);
        step(); expect_elem("basic1", 8'h22);
        step(); expect_elem("basic2", 8'h33);
        step(); expect_elem("basic3", 8'h44);
        step(); expect_idle("basic_end");

        // 3. backpressure after element 22
        load_word(32'h44332211);
        expect_elem("bp0", 8'h11);
        step(); expect_elem("bp1", 8'h22);
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); expect_elem("bp_hold", 8'h22);
        end
        ready_i = 1'b1;
        step(); expect_elem("bp2", 8'h33);
        step(); expect_elem("bp3", 8'h44);
        step(); expect_idle("bp_end");

        // 4. load attempt while busy is ignored
        load_word(32'h44332211);
        expect_elem("busy0", 8'h11);
        valid_i = 1'b1;
        data_i  = 32'hDEADBEEF;
        chk("busy_ready", {31'd0, ready_o}, 32'd0);
        step(); expect_elem("busy1", 8'h22);
        step(); expect_elem("busy2", 8'h33);
        step(); expect_elem("busy3", 8'h44);
        valid_i = 1'b0;
        step(); expect_idle("busy_end");

        // 5. reset in the middle of a word
        load_word(32'h44332211);
        expect_elem("mid0", 8'h11);
        step(); expect_elem("mid1", 8'h22);
        reset_ni = 1'b0;
        step();
        chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
        reset_ni = 1'b1;
        #1;
        expect_idle("mid_release");
        step();
        load_word(32'h0A0B0C0D);
        expect_elem("mid_new0", 8'h0D);
        step(); expect_elem("mid_new1", 8'h0C);
        step(); expect_elem("mid_new2", 8'h0B);
        step(); expect_elem("mid_new3", 8'h0A);
        step(); expect_idle("mid_new_end");

        // 6. two words offered back to back
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`ifndef PISO_BACK2BACK_EN
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88};
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        valid_i = 1'b1;
        data_i  = 32'h44332211;
        step();
        data_i = 32'h88776655;
        begin
            logic flag;
            flag = 1'b0;
            for (int i = 0; i < 9; i++) begin
                rec_v[i] = valid_o;
                rec_d[i] = data_o;
                if (flag) valid_i = 1'b0;
                flag = valid_i && ready_o;
                step();
            end
        end
        valid_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("b2b_valid%0d", i), {31'd0, rec_v[i]}, {31'd0, exp_v[i]});
            if (exp_v[i]) chk($sformatf("b2b_data%0d", i), {24'd0, rec_d[i]}, {24'd0, exp_d[i]});
        end
        for (int i = 0; i < 6; i++) step();

        model_en = 1'b0;
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
